// File: rtl/approx_sweep_pkg.sv
// Shared types and arithmetic helpers for the approximate-adder error sweeper.
// Helpers work on 32-bit values so the modules can size the results to their own widths.
package approx_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } state_e;

    // Operand a is the low half of the vector, operand b the high half.
    function automatic int unsigned exact_sum(input int unsigned vec, input int unsigned ni);
        int unsigned half;
        int unsigned mask;
        half = ni / 2;
        mask = (32'd1 << half) - 32'd1;
        return (vec & mask) + ((vec >> half) & mask);
    endfunction

    function automatic int unsigned abs_diff(input int unsigned x, input int unsigned y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/approx_sweep_acc.sv
// Per-sample error accumulator: running max, nonzero-error count, error sum and
// a latch of the first vector whose error exceeds the threshold.
module approx_sweep_acc
    import approx_sweep_pkg::*;
#(
    parameter int unsigned NI = 4,
    parameter int unsigned NO = 3,
    parameter int unsigned ET = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [NO-1:0]    err_i,
    input  logic [NI-1:0]    vec_i,
    output logic [NO-1:0]    max_err_o,
    output logic [NI:0]      err_count_o,
    output logic [NI+NO-1:0] err_sum_o,
    output logic [NI-1:0]    fail_vec_o,
    output logic [NO-1:0]    max_next_o,
    output logic             over_et_o
);

    logic [NO-1:0]    max_q;
    logic [NI:0]      count_q;
    logic [NI+NO-1:0] sum_q;
    logic [NI-1:0]    fail_vec_q;
    logic             fail_seen_q;

    assign over_et_o  = 32'(err_i) > ET;
    // Exposed so the sequencer can judge pass/fail in the same cycle as the last sample.
    assign max_next_o = (en_i && (err_i > max_q)) ? err_i : max_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would chain updates within one clock.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            max_q       <= '0;
            count_q     <= '0;
            sum_q       <= '0;
            fail_vec_q  <= '0;
            fail_seen_q <= 1'b0;
        end else if (en_i) begin
            max_q   <= max_next_o;
            count_q <= count_q + {{NI{1'b0}}, (err_i != '0)};
            sum_q   <= sum_q + (NI+NO)'(err_i);
            if (over_et_o && !fail_seen_q) begin
                fail_vec_q  <= vec_i;
                fail_seen_q <= 1'b1;
            end
        end
    end

    assign max_err_o   = max_q;
    assign err_count_o = count_q;
    assign err_sum_o   = sum_q;
    assign fail_vec_o  = fail_vec_q;

endmodule

// File: rtl/approx_adder_error_sweeper.sv
// Sequencer that drives every input vector into a combinational approximate adder,
// waits LAT cycles, and accumulates the error against the exact sum.
module approx_adder_error_sweeper
    import approx_sweep_pkg::*;
#(
    parameter int unsigned NI         = 4,
    parameter int unsigned NO         = 3,
    parameter int unsigned ET         = 4,
    parameter int unsigned LAT        = 1,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [NI-1:0]    approx_in,
    input  logic [NO-1:0]    approx_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [NO-1:0]    max_err,
    output logic [NI:0]      err_count,
    output logic [NI+NO-1:0] err_sum,
    output logic [NI-1:0]    fail_vec
);

    localparam int unsigned   WW        = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(LAT - 1);
    localparam logic [NI-1:0] VEC_LAST  = '1;

    state_e        state_q, state_d;
    logic [NI-1:0] vec_q, vec_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          pass_q, pass_d;

    logic          acc_clr, acc_en, over_et;
    logic [NO-1:0] exact, err, max_next;

    assign exact = NO'(exact_sum(32'(vec_q), NI));
    assign err   = NO'(abs_diff(32'(approx_out), 32'(exact)));

    approx_sweep_acc #(
        .NI (NI),
        .NO (NO),
        .ET (ET)
    ) u_acc (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (acc_clr),
        .en_i        (acc_en),
        .err_i       (err),
        .vec_i       (vec_q),
        .max_err_o   (max_err),
        .err_count_o (err_count),
        .err_sum_o   (err_sum),
        .fail_vec_o  (fail_vec),
        .max_next_o  (max_next),
        .over_et_o   (over_et)
    );

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        wait_d  = wait_q;
        pass_d  = pass_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_clr = 1'b1;
                    pass_d  = 1'b0;
                    vec_d   = '0;
                    wait_d  = '0;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                if (abort) begin
                    wait_d  = '0;
                    state_d = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = SAMPLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    acc_en = 1'b1;
                    if ((vec_q == VEC_LAST) || (EARLY_EXIT && over_et)) begin
                        pass_d  = 32'(max_next) <= ET;
                        state_d = DONE;
                    end else begin
                        vec_d   = vec_q + 1'b1;
                        state_d = APPLY;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            wait_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            wait_q  <= wait_d;
            pass_q  <= pass_d;
        end
    end

    // approx_in is the vector register itself, so it holds through SAMPLE and in IDLE.
    assign approx_in = vec_q;
    assign busy      = (state_q == APPLY) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;

endmodule

// File: tb/tb_approx_adder_error_sweeper.sv
// Directed bench: three sweeper instances (defaults, early exit, LAT=3) each beside a
// mode-selectable adder stub; cycle 0 is the cycle in which start is driven.
module tb_approx_adder_error_sweeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   mode = 0;  // 0: exact adder, 1: constant zero, 2: exact except vec 5 -> exact+1
    int   checks = 0;
    int   failures = 0;
    int   done_cnt [3];

    logic [2:0] start_v = '0;
    logic [2:0] abort_v = '0;
    logic [2:0] busy_v, done_v, pass_v;
    logic [3:0] ain_v  [3];
    logic [2:0] aout_v [3];
    logic [2:0] max_v  [3];
    logic [4:0] cnt_v  [3];
    logic [6:0] sum_v  [3];
    logic [3:0] fv_v   [3];

    always #5 clk = ~clk;

    function automatic logic [2:0] stub_f(input int m, input logic [3:0] v);
        logic [2:0] ex;
        ex = 3'(v[1:0]) + 3'(v[3:2]);
        case (m)
            1:       return 3'd0;
            2:       return (v == 4'd5) ? ex + 3'd1 : ex;
            default: return ex;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) aout_v[i] = stub_f(mode, ain_v[i]);
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) if (done_v[i] === 1'b1) done_cnt[i]++;
    end

    approx_adder_error_sweeper u_dut (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
        .approx_in(ain_v[0]), .approx_out(aout_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .max_err(max_v[0]), .err_count(cnt_v[0]), .err_sum(sum_v[0]),
        .fail_vec(fv_v[0])
    );

    approx_adder_error_sweeper #(.EARLY_EXIT(1'b1)) u_dut_ee (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
        .approx_in(ain_v[1]), .approx_out(aout_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .max_err(max_v[1]), .err_count(cnt_v[1]), .err_sum(sum_v[1]),
        .fail_vec(fv_v[1])
    );

    approx_adder_error_sweeper #(.LAT(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]),
        .approx_in(ain_v[2]), .approx_out(aout_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .max_err(max_v[2]), .err_count(cnt_v[2]), .err_sum(sum_v[2]),
        .fail_vec(fv_v[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives start in cycle 0 (plus optionally in cycle repulse_at) and returns the cycle
    // in which done is first seen, or budget if it never arrives.
    task automatic run_sweep(input int w, input int budget, input int repulse_at, output int n);
        start_v[w] = 1'b1;
        n = 0;
        while (n < budget) begin
            tick();
            n++;
            start_v[w] = (n == repulse_at);
            if (done_v[w] === 1'b1) break;
        end
        start_v[w] = 1'b0;
    endtask

    task automatic check_results(input string tag, input int w, input int mx, input int cnt,
                                 input int sum, input int ps, input int fv);
        check({tag, "_max_err"},   32'(max_v[w]),  mx);
        check({tag, "_err_count"}, 32'(cnt_v[w]),  cnt);
        check({tag, "_err_sum"},   32'(sum_v[w]),  sum);
        check({tag, "_pass"},      32'(pass_v[w]), ps);
        check({tag, "_fail_vec"},  32'(fv_v[w]),   fv);
    endtask

    initial begin
        int n;
        int done_before;
        for (int i = 0; i < 3; i++) done_cnt[i] = 0;

        // Reset state of every instance
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy%0d", i),      32'(busy_v[i]), 0);
            check($sformatf("rst_done%0d", i),      32'(done_v[i]), 0);
            check($sformatf("rst_approx_in%0d", i), 32'(ain_v[i]),  0);
        end
        check_results("rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // Exact stub: no error, done in cycle 33
        mode = 0;
        run_sweep(0, 100, -1, n);
        check("exact_done_cycle", n, 33);
        check_results("exact", 0, 0, 0, 0, 1, 0);
        tick();
        check("exact_done_one_cycle", 32'(done_v[0]), 0);
        check("exact_pass_held", 32'(pass_v[0]), 1);
        check("exact_idle_holds_last_vec", 32'(ain_v[0]), 15);

        // Zero stub: error equals a+b
        mode = 1;
        run_sweep(0, 100, -1, n);
        check("zero_done_cycle", n, 33);
        check_results("zero", 0, 6, 15, 48, 0, 11);
        tick();

        // Zero stub, early exit at vec 11 (a=3,b=2); sum of a+b over vec 0..11 is 30
        run_sweep(1, 100, -1, n);
        check("ee_done_cycle", n, 25);
        check_results("ee", 1, 5, 11, 30, 0, 11);
        tick();

        // Abort in cycle 10 (SAMPLE of vec 4): vecs 0..3 accumulated
        done_before = done_cnt[0];
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (9) tick();
        check("abort_busy_before", 32'(busy_v[0]), 1);
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        check("abort_busy_after", 32'(busy_v[0]), 0);
        check_results("abort", 0, 3, 3, 6, 0, 0);
        check("abort_vec_held", 32'(ain_v[0]), 4);
        repeat (40) tick();
        check("abort_no_done", done_cnt[0], done_before);

        // Restart after abort begins again at vec 0 with cleared accumulators
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        check("restart_vec0", 32'(ain_v[0]), 0);
        check("restart_sum_clr", 32'(sum_v[0]), 0);
        check("restart_busy", 32'(busy_v[0]), 1);
        n = 1;
        while (n < 100 && done_v[0] !== 1'b1) begin
            tick();
            n++;
        end
        check("restart_done_cycle", n, 33);
        check("restart_err_sum", 32'(sum_v[0]), 48);
        tick();

        // start re-pulsed mid-sweep is ignored
        run_sweep(0, 100, 7, n);
        check("repulse_done_cycle", n, 33);
        check("repulse_err_count", 32'(cnt_v[0]), 15);
        tick();

        // Reset mid-sweep clears every output next cycle
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", 32'(busy_v[0]), 0);
        check("midrst_approx_in", 32'(ain_v[0]), 0);
        check_results("midrst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // LAT=3 with exact stub: 16*4+1 cycles
        mode = 0;
        run_sweep(2, 200, -1, n);
        check("lat3_done_cycle", n, 65);
        check_results("lat3", 2, 0, 0, 0, 1, 0);
        tick();

        // Single off-by-one error at vec 5
        mode = 2;
        run_sweep(0, 100, -1, n);
        check("vec5_done_cycle", n, 33);
        check_results("vec5", 0, 1, 1, 1, 1, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
